parity_rx: RTL

PARITY_RX -- requirements
Module: parity_rx

---
 rtl/parity_rx.sv | 107 ++++++++++
 1 files changed

// File: rtl/parity_rx.sv
// rtl/parity_rx.sv - serial nibble receiver with even-parity check and single-entry holding register
module parity_rx (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_en,
    input  logic       sin,
    input  logic       rdy,
    output logic [3:0] data,
    output logic       valid,
    output logic       perr,
    output logic       ferr,
    output logic       overrun,
    output logic [7:0] err_cnt,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] bit_idx;
    logic [3:0] shreg;
    logic       par_bad;
    logic       stop_strobe;
    logic       hold_free;
    logic       frame_err;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_en && !sin) state_next = DATA;
            DATA:    if (sample_en && bit_idx == 2'd3) state_next = PARITY;
            PARITY:  if (sample_en) state_next = STOP;
            STOP:    if (sample_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign stop_strobe = (state == STOP) && sample_en;
    // A consumer taking the held frame this cycle frees the slot for a same-cycle load.
    assign hold_free   = !valid || rdy;
    assign frame_err   = par_bad | ~sin;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_idx <= 2'd0;
            shreg   <= 4'd0;
            par_bad <= 1'b0;
            data    <= 4'd0;
            valid   <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            overrun <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            if (sample_en) begin
                case (state)
                    IDLE: begin
                        bit_idx <= 2'd0;
                    end
                    DATA: begin
                        // LSB arrives first, so shift in from the top.
                        shreg   <= {sin, shreg[3:1]};
                        bit_idx <= bit_idx + 2'd1;
                    end
                    PARITY: begin
                        par_bad <= sin ^ (^shreg);
                    end
                    default: begin
                    end
                endcase
            end

            if (stop_strobe && hold_free) begin
                data  <= shreg;
                perr  <= par_bad;
                ferr  <= ~sin;
                valid <= 1'b1;
                if (frame_err && err_cnt != 8'hff) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end else begin
                if (stop_strobe) begin
                    overrun <= 1'b1;
                end
                if (valid && rdy) begin
                    valid <= 1'b0;
                end
            end
        end
    end

endmodule
